fifo_packetizer: RTL and testbench

Downstream consumer of the team's synchronous FIFO (sync_FIFO_dut). It drains 8-bit words from the FIFO read side and frames them into fixed-length packets on a valid/ready stream. Each packet is one header word, PKT_LEN payload words and one XOR checksum word. It sits between the FIFO and the link/transmit stage.

---
 rtl/fifo_packetizer_if.sv | 33 +++
 rtl/fifo_packetizer.sv | 126 ++++++++++++
 tb/tb_fifo_packetizer.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_packetizer_if.sv
// Bundle of the FIFO read-side and outgoing stream signals used by fifo_packetizer.
// The master modport is the packetizer's view; the slave modport is the FIFO/link view.
interface fifo_packetizer_if #(
    parameter int DWIDTH = 8
);
    logic              fifo_empty;
    logic [DWIDTH-1:0] fifo_dout;
    logic              fifo_rd;
    logic              m_valid;
    logic [DWIDTH-1:0] m_data;
    logic              m_last;
    logic              m_ready;

    modport master (
        input  fifo_empty,
        input  fifo_dout,
        input  m_ready,
        output fifo_rd,
        output m_valid,
        output m_data,
        output m_last
    );

    modport slave (
        output fifo_empty,
        output fifo_dout,
        output m_ready,
        input  fifo_rd,
        input  m_valid,
        input  m_data,
        input  m_last
    );
endinterface

// File: rtl/fifo_packetizer.sv
// Drains words from a synchronous FIFO and frames them as packets on a valid/ready
// stream: one header word, PKT_LEN payload words, then an XOR checksum of the payload
// marked with m_last. Every payload word is popped, captured, then offered, so the
// FIFO strobe can never fire twice in a row and the stream data never changes while stalled.
module fifo_packetizer #(
    parameter int                DWIDTH   = 8,
    parameter int                PKT_LEN  = 4,
    parameter logic [DWIDTH-1:0] HDR_WORD = DWIDTH'(8'hA5)
) (
    input  logic                  clk,
    input  logic                  rst,
    fifo_packetizer_if.master     bus,
    output logic [15:0]           pkt_count
);

    // Index of the final payload word; the counter holds how many words were already accepted.
    localparam logic [7:0] LAST_IDX = 8'(PKT_LEN - 1);

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        POP,
        CAP,
        SEND,
        CSUM
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [DWIDTH-1:0] data_reg;
    logic [DWIDTH-1:0] checksum;
    logic [7:0]        word_cnt;

    // State register; reset abandons any packet in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and stream/FIFO outputs decoded from the current state.
    always_comb begin
        next_state  = state;
        bus.fifo_rd = 1'b0;
        bus.m_valid = 1'b0;
        bus.m_data  = '0;
        bus.m_last  = 1'b0;
        case (state)
            IDLE: begin
                if (!bus.fifo_empty) begin
                    next_state = HDR;
                end
            end
            HDR: begin
                bus.m_valid = 1'b1;
                bus.m_data  = HDR_WORD;
                if (bus.m_ready) begin
                    next_state = POP;
                end
            end
            POP: begin
                if (!bus.fifo_empty) begin
                    bus.fifo_rd = 1'b1;
                    next_state  = CAP;
                end
            end
            CAP: begin
                next_state = SEND;
            end
            SEND: begin
                bus.m_valid = 1'b1;
                bus.m_data  = data_reg;
                if (bus.m_ready) begin
                    next_state = (word_cnt == LAST_IDX) ? CSUM : POP;
                end
            end
            CSUM: begin
                bus.m_valid = 1'b1;
                bus.m_data  = checksum;
                bus.m_last  = 1'b1;
                if (bus.m_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Payload capture, running checksum, word counter and completed-packet counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_reg  <= '0;
            checksum  <= '0;
            word_cnt  <= '0;
            pkt_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    checksum <= '0;
                    word_cnt <= '0;
                end
                CAP: begin
                    data_reg <= bus.fifo_dout;
                end
                SEND: begin
                    if (bus.m_ready) begin
                        checksum <= checksum ^ data_reg;
                        word_cnt <= word_cnt + 8'd1;
                    end
                end
                CSUM: begin
                    if (bus.m_ready) begin
                        pkt_count <= pkt_count + 16'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_packetizer.sv
// Scoreboard bench for fifo_packetizer: a queue-based FIFO model feeds the DUT, a
// streaming packet model queues the expected words, and a monitor checks every
// accepted word, stream stability while stalled and the FIFO strobe rules.
module tb_fifo_packetizer;

    localparam int         DWIDTH  = 8;
    localparam int         PKT_LEN = 4;
    localparam logic [7:0] HDR     = 8'hA5;

    typedef struct {
        logic [7:0] data;
        logic       last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] pkt_count;

    fifo_packetizer_if #(.DWIDTH(DWIDTH)) bus ();

    fifo_packetizer #(
        .DWIDTH  (DWIDTH),
        .PKT_LEN (PKT_LEN),
        .HDR_WORD(HDR)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .pkt_count(pkt_count)
    );

    // Free-running 10-time-unit clock.
    always #5 clk = ~clk;

    logic [7:0] fifo_q[$];
    exp_t       exp_q[$];
    int         model_cnt = 0;
    logic [7:0] model_ck = 8'h00;
    int         pkts_formed = 0;
    int         n_cmp = 0;
    int         n_err = 0;
    int         rd_count = 0;
    int         hs_count = 0;
    int         ready_mode = 0;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Streaming packet model: header on the first word of a packet, XOR checksum after PKT_LEN words.
    function automatic void model_add(input logic [7:0] w);
        if (model_cnt == 0) exp_q.push_back('{HDR, 1'b0});
        exp_q.push_back('{w, 1'b0});
        model_ck = model_ck ^ w;
        model_cnt++;
        if (model_cnt == PKT_LEN) begin
            exp_q.push_back('{model_ck, 1'b1});
            model_cnt = 0;
            model_ck  = 8'h00;
            pkts_formed++;
        end
    endfunction

    // After a reset the DUT restarts from whatever is still in the FIFO.
    function automatic void model_rebuild();
        exp_q.delete();
        model_cnt   = 0;
        model_ck    = 8'h00;
        pkts_formed = 0;
        foreach (fifo_q[i]) model_add(fifo_q[i]);
    endfunction

    task automatic apply_stimulus(input logic [7:0] w);
        @(negedge clk);
        fifo_q.push_back(w);
        model_add(w);
    endtask

    task automatic reset_dut();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        model_rebuild();
        check_output("rst_m_valid", bus.m_valid, 0);
        check_output("rst_fifo_rd", bus.fifo_rd, 0);
        check_output("rst_m_data", bus.m_data, 0);
        check_output("rst_m_last", bus.m_last, 0);
        check_output("rst_pkt_count", pkt_count, 0);
    endtask

    task automatic wait_drain(input string name);
        int guard = 0;
        while (exp_q.size() != 0 && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        check_output({name, "_drain"}, exp_q.size(), 0);
        repeat (3) @(negedge clk);
        check_output({name, "_pkt_count"}, pkt_count, pkts_formed);
    endtask

    // Registered FIFO model: strobe sampled mid-cycle, pop and empty flag update on the edge.
    initial begin
        logic rd_seen;
        logic prev_rd;
        prev_rd = 1'b0;
        bus.fifo_empty <= 1'b1;
        bus.fifo_dout  <= 8'h00;
        forever begin
            @(negedge clk);
            rd_seen = bus.fifo_rd;
            if (rd_seen) begin
                check_output("rd_while_empty", bus.fifo_empty, 0);
                check_output("rd_back_to_back", prev_rd, 0);
            end
            prev_rd = rd_seen;
            @(posedge clk);
            if (rd_seen) begin
                rd_count++;
                if (fifo_q.size() > 0) bus.fifo_dout <= fifo_q.pop_front();
            end
            bus.fifo_empty <= (fifo_q.size() == 0);
        end
    end

    // Downstream ready driver: always ready, 5-cycle stall per word, random, or held off.
    initial begin
        int wcnt;
        wcnt = 0;
        bus.m_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: bus.m_ready = 1'b1;
                1: begin
                    if (!bus.m_valid) begin
                        wcnt = 0;
                        bus.m_ready = 1'b0;
                    end else if (wcnt < 5) begin
                        wcnt++;
                        bus.m_ready = 1'b0;
                    end else begin
                        bus.m_ready = 1'b1;
                    end
                end
                2: bus.m_ready = ($urandom_range(0, 3) != 0);
                default: bus.m_ready = 1'b0;
            endcase
        end
    end

    // Monitor: compares each accepted word against the scoreboard and checks stall stability.
    initial begin
        logic       stall;
        logic [7:0] sd;
        logic       sl;
        exp_t       e;
        stall = 1'b0;
        sd    = 8'h00;
        sl    = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall = 1'b0;
            end else begin
                if (stall) begin
                    check_output("stall_valid", bus.m_valid, 1);
                    check_output("stall_data", bus.m_data, sd);
                    check_output("stall_last", bus.m_last, sl);
                end
                if (bus.m_valid && bus.m_ready) begin
                    hs_count++;
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("[TB] FAIL unexpected_word: got %0h, required no word", bus.m_data);
                    end else begin
                        e = exp_q.pop_front();
                        check_output("word_data", bus.m_data, e.data);
                        check_output("word_last", bus.m_last, e.last);
                    end
                end
                stall = bus.m_valid && !bus.m_ready;
                sd    = bus.m_data;
                sl    = bus.m_last;
            end
        end
    end

    // Watchdog so the run can never hang.
    initial begin
        #600000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Test sequence.
    initial begin
        int rd0;
        int base;
        int guard;
        logic [7:0] w;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_rebuild();
        check_output("init_m_valid", bus.m_valid, 0);
        check_output("init_m_last", bus.m_last, 0);
        check_output("init_m_data", bus.m_data, 0);
        check_output("init_pkt_count", pkt_count, 0);

        $display("[TB] basic packet, ready held high");
        ready_mode = 0;
        rd0 = rd_count;
        for (int i = 1; i <= 4; i++) apply_stimulus(8'(i));
        wait_drain("t1");
        check_output("t1_rd_pulses", rd_count - rd0, 4);

        $display("[TB] same data, 5-cycle stall on every word");
        ready_mode = 1;
        rd0 = rd_count;
        for (int i = 1; i <= 4; i++) apply_stimulus(8'(i));
        wait_drain("t2");
        check_output("t2_rd_pulses", rd_count - rd0, 4);

        $display("[TB] FIFO underrun mid-packet");
        ready_mode = 0;
        rd0 = rd_count;
        apply_stimulus(8'h10);
        apply_stimulus(8'h20);
        repeat (20) @(negedge clk);
        check_output("t3_parked_valid", bus.m_valid, 0);
        check_output("t3_parked_rd", bus.fifo_rd, 0);
        check_output("t3_parked_words_left", exp_q.size(), 0);
        apply_stimulus(8'h30);
        apply_stimulus(8'h40);
        wait_drain("t3");
        check_output("t3_rd_pulses", rd_count - rd0, 4);

        $display("[TB] two back-to-back packets");
        rd0 = rd_count;
        for (int i = 8'h11; i <= 8'h18; i++) apply_stimulus(8'(i));
        wait_drain("t4");
        check_output("t4_rd_pulses", rd_count - rd0, 8);

        $display("[TB] reset after second payload word");
        ready_mode = 3;
        rd0  = rd_count;
        base = hs_count;
        for (int i = 8'h21; i <= 8'h28; i++) apply_stimulus(8'(i));
        ready_mode = 0;
        guard = 0;
        while (hs_count < base + 3 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check_output("t5_reached_payload2", (hs_count >= base + 3), 1);
        reset_dut();
        check_output("t5_rd_before_reset", rd_count - rd0, 3);
        apply_stimulus(8'h29);
        apply_stimulus(8'h2A);
        apply_stimulus(8'h2B);
        wait_drain("t5");

        $display("[TB] idle with empty FIFO");
        reset_dut();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check_output("t6_idle_valid", bus.m_valid, 0);
            check_output("t6_idle_rd", bus.fifo_rd, 0);
        end
        check_output("t6_pkt_count", pkt_count, 0);

        $display("[TB] random data, random ready and push gaps");
        ready_mode = 2;
        rd0 = rd_count;
        for (int i = 0; i < 3 * PKT_LEN; i++) begin
            w = 8'($urandom_range(0, 255));
            apply_stimulus(w);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_drain("t7");
        check_output("t7_rd_pulses", rd_count - rd0, 3 * PKT_LEN);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
